issue_queue_multi: RTL and testbench
====================================

Name: issue_queue_multi

Overview:
- Parametrised multi-entry issue queue; generalises the single-entry issue slot to DEPTH entries.
- Adds NUM_WB writeback wakeup ports with same-cycle enqueue bypass, oldest-first select by ROB age, and branch/exception flush of younger entries.
- Sits between rename/dispatch and one execution pipe; carries the decoded micro-op as an opaque payload.

Parameters:
DEPTH, 8, number of entries (power of 2, >=2)
NUM_WB, 2, number of writeback wakeup ports
PREG_W, 6, physical register index width
ROB_W, 6, ROB index width (excluding wrap flag)
PAYLOAD_W, 128, opaque micro-op payload width (pc, instr, imm, prd, types, ...)

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
enq_valid  in  1  dispatch offers a micro-op
enq_ready  out  1  queue can accept this cycle
enq_prs1  in  PREG_W  source 1 physical register
enq_prs2  in  PREG_W  source 2 physical register
enq_src1_state  in  1  source 1 already available
enq_src2_state  in  1  source 2 already available
enq_robidx_flag  in  1  ROB wrap flag
enq_robidx  in  ROB_W  ROB index
enq_payload  in  PAYLOAD_W  remaining micro-op fields
wb_valid  in  NUM_WB  writeback port valid
wb_prd  in  NUM_WB*PREG_W  writeback destination pregs, port i at [i*PREG_W +: PREG_W]
issue_valid  out  1  selected entry presented
issue_ready  in  1  execution pipe accepts
issue_prs1  out  PREG_W  selected source 1
issue_prs2  out  PREG_W  selected source 2
issue_robidx_flag  out  1  selected ROB flag
issue_robidx  out  ROB_W  selected ROB index
issue_payload  out  PAYLOAD_W  selected payload
flush_valid  in  1  redirect; kill strictly younger entries
flush_robidx_flag  in  1  flush point flag
flush_robidx  in  ROB_W  flush point index
occupancy  out  $clog2(DEPTH)+1  valid entry count (registered)

Behaviour:
- Reset (sync, clock edge with reset=1): all entry valid bits 0, occupancy 0. issue_valid=0 and enq_ready=1 after reset. Reset mid-operation discards all contents.
- Age: A older than B iff (A.flag==B.flag) ? A.idx<B.idx : A.idx>B.idx.
- enq_ready = !flush_valid && occupancy<DEPTH. It does not count a same-cycle issue as a free slot.
- Enqueue fires on enq_valid&&enq_ready and writes the lowest-index invalid entry.
- Enqueue bypass: a stored src_state = enq_srcN_state OR (any wb_valid[i] with wb_prd[i]==enq_prsN).
- Wakeup: each valid entry sets srcN_state when any wb_valid[i] && wb_prd[i]==prsN. States only set, never cleared, while the entry is valid.
- Ready = valid && src1_state && src2_state, all from registered state. Entry enqueued or woken in cycle T is issuable in T+1 at the earliest.
- Select (combinational): the oldest ready entry. issue_valid = any ready && !flush_valid. Outputs are driven from the selected entry; when issue_valid=0 the outputs are don't-care.
- Issue handshake: issue_valid&&issue_ready invalidates the selected entry at the clock edge. The slot is reusable from the next cycle. With issue_ready=0, the selection may change next cycle if an older entry becomes ready.
- Flush: flush_valid invalidates every valid entry strictly younger than the flush point; the entry equal to the flush point survives. In a flush cycle enqueue and issue are both suppressed.
- occupancy next = occupancy + enq_fire - issue_fire - flushed_count. Never exceeds DEPTH and never underflows; assertion-checked.
- Simultaneous enqueue and issue in one cycle: both take effect. When full, enq_ready stays 0 even while an issue fires.
- A wakeup matching a preg that no entry is waiting on has no effect. Duplicate matches on multiple ports are idempotent.

Test Plan:
- Reset then enqueue robidx 3 with both states=1 at T0 -> issue_valid=1 at T1 with issue_robidx=3. Handshake at T1 -> occupancy 0 at T2.
- Enqueue prs1=12 with state 0 while wb_valid[1]=1, wb_prd=12 in the same cycle -> entry is ready and issues next cycle (bypass check).
- Fill 8 entries with states 0 -> enq_ready=0 and occupancy=8. Wake prs 5 on port 0 -> only entries waiting on 5 become ready, one cycle later.
- Ready entries robidx 60 (flag 0) and 2 (flag 1) -> 60 is selected first. With issue_ready=0 for 3 cycles, the selection holds at 60.
- Entries robidx 4, 7, 9 (flag 0); flush at 7 -> only 4 and 7 remain, occupancy=2. issue_valid=0 and enq_ready=0 during the flush cycle.
- Queue at 5 entries with reset asserted for one cycle mid-stream -> occupancy=0 and issue_valid=0. A wakeup applied afterwards produces no issue.

Source files
------------

// File: rtl/issue_queue_multi_if.sv
// Dispatch / writeback / issue / flush bundle for the multi-entry issue queue.
// The queue side uses the slave modport; the dispatch/execution environment uses master.
interface issue_queue_multi_if #(
  parameter int DEPTH     = 8,
  parameter int NUM_WB    = 2,
  parameter int PREG_W    = 6,
  parameter int ROB_W     = 6,
  parameter int PAYLOAD_W = 128
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic                     enq_valid;
  logic                     enq_ready;
  logic [PREG_W-1:0]        enq_prs1;
  logic [PREG_W-1:0]        enq_prs2;
  logic                     enq_src1_state;
  logic                     enq_src2_state;
  logic                     enq_robidx_flag;
  logic [ROB_W-1:0]         enq_robidx;
  logic [PAYLOAD_W-1:0]     enq_payload;
  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB*PREG_W-1:0] wb_prd;
  logic                     issue_valid;
  logic                     issue_ready;
  logic [PREG_W-1:0]        issue_prs1;
  logic [PREG_W-1:0]        issue_prs2;
  logic                     issue_robidx_flag;
  logic [ROB_W-1:0]         issue_robidx;
  logic [PAYLOAD_W-1:0]     issue_payload;
  logic                     flush_valid;
  logic                     flush_robidx_flag;
  logic [ROB_W-1:0]         flush_robidx;
  logic [OCC_W-1:0]         occupancy;

  modport slave (
    input  enq_valid, enq_prs1, enq_prs2, enq_src1_state, enq_src2_state,
           enq_robidx_flag, enq_robidx, enq_payload, wb_valid, wb_prd,
           issue_ready, flush_valid, flush_robidx_flag, flush_robidx,
    output enq_ready, issue_valid, issue_prs1, issue_prs2, issue_robidx_flag,
           issue_robidx, issue_payload, occupancy
  );

  modport master (
    output enq_valid, enq_prs1, enq_prs2, enq_src1_state, enq_src2_state,
           enq_robidx_flag, enq_robidx, enq_payload, wb_valid, wb_prd,
           issue_ready, flush_valid, flush_robidx_flag, flush_robidx,
    input  enq_ready, issue_valid, issue_prs1, issue_prs2, issue_robidx_flag,
           issue_robidx, issue_payload, occupancy
  );
endinterface

// File: rtl/issue_queue_multi.sv
// DEPTH-entry issue queue: wakeup from NUM_WB writeback ports with enqueue bypass,
// oldest-ready select by ROB age, and flush of entries younger than a redirect point.
module issue_queue_multi #(
  parameter int DEPTH     = 8,
  parameter int NUM_WB    = 2,
  parameter int PREG_W    = 6,
  parameter int ROB_W     = 6,
  parameter int PAYLOAD_W = 128
) (
  input logic clock,
  input logic reset,
  issue_queue_multi_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;

  logic [DEPTH-1:0]     ent_vld_p1;
  logic [DEPTH-1:0]     ent_src1_p1;
  logic [DEPTH-1:0]     ent_src2_p1;
  logic [DEPTH-1:0]     ent_flag_p1;
  logic [PREG_W-1:0]    ent_prs1_p1 [DEPTH];
  logic [PREG_W-1:0]    ent_prs2_p1 [DEPTH];
  logic [ROB_W-1:0]     ent_idx_p1  [DEPTH];
  logic [PAYLOAD_W-1:0] ent_pl_p1   [DEPTH];
  logic [OCC_W-1:0]     occ_p1;

  logic [DEPTH-1:0]        ready;
  logic [DEPTH-1:0]        kill;
  logic                    sel_found;
  logic [IDX_W-1:0]        sel_idx;
  logic [IDX_W-1:0]        free_idx;
  logic [OCC_W-1:0]        flushed_count;
  logic                    enq_fire;
  logic                    issue_fire;
  logic signed [OCC_W+1:0] occ_sum;

  function automatic logic is_older(input logic fa, input logic [ROB_W-1:0] ia,
                                    input logic fb, input logic [ROB_W-1:0] ib);
    return (fa == fb) ? (ia < ib) : (ia > ib);
  endfunction

  function automatic logic wb_hit(input logic [PREG_W-1:0] preg,
                                  input logic [NUM_WB-1:0] vld,
                                  input logic [NUM_WB*PREG_W-1:0] prd);
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < NUM_WB; w++)
      if (vld[w] && prd[w*PREG_W +: PREG_W] == preg) hit = 1'b1;
    return hit;
  endfunction

  // Combinational select, allocation and flush evaluation over registered entry state
  assign ready = ent_vld_p1 & ent_src1_p1 & ent_src2_p1;

  always_comb begin
    sel_found     = 1'b0;
    sel_idx       = '0;
    free_idx      = '0;
    flushed_count = '0;
    kill          = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!sel_found ||
          is_older(ent_flag_p1[i], ent_idx_p1[i], ent_flag_p1[sel_idx], ent_idx_p1[sel_idx]))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      kill[i] = bus.flush_valid && ent_vld_p1[i] &&
                is_older(bus.flush_robidx_flag, bus.flush_robidx, ent_flag_p1[i], ent_idx_p1[i]);
      flushed_count = flushed_count + OCC_W'(kill[i]);
    end
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!ent_vld_p1[i]) free_idx = IDX_W'(i);
  end

  assign bus.enq_ready         = !bus.flush_valid && (occ_p1 < OCC_W'(DEPTH));
  assign bus.issue_valid       = sel_found && !bus.flush_valid;
  assign enq_fire              = bus.enq_valid && bus.enq_ready;
  assign issue_fire            = bus.issue_valid && bus.issue_ready;
  assign bus.issue_prs1        = ent_prs1_p1[sel_idx];
  assign bus.issue_prs2        = ent_prs2_p1[sel_idx];
  assign bus.issue_robidx_flag = ent_flag_p1[sel_idx];
  assign bus.issue_robidx      = ent_idx_p1[sel_idx];
  assign bus.issue_payload     = ent_pl_p1[sel_idx];
  assign bus.occupancy         = occ_p1;

  assign occ_sum = $signed({2'b00, occ_p1})
                 + $signed({{(OCC_W+1){1'b0}}, enq_fire})
                 - $signed({{(OCC_W+1){1'b0}}, issue_fire})
                 - $signed({2'b00, flushed_count});

  // Entry control state and occupancy register
  always_ff @(posedge clock) begin
    if (reset) begin
      ent_vld_p1  <= '0;
      ent_src1_p1 <= '0;
      ent_src2_p1 <= '0;
      occ_p1      <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill[i] || (issue_fire && sel_idx == IDX_W'(i))) ent_vld_p1[i] <= 1'b0;
        if (ent_vld_p1[i] && wb_hit(ent_prs1_p1[i], bus.wb_valid, bus.wb_prd)) ent_src1_p1[i] <= 1'b1;
        if (ent_vld_p1[i] && wb_hit(ent_prs2_p1[i], bus.wb_valid, bus.wb_prd)) ent_src2_p1[i] <= 1'b1;
      end
      if (enq_fire) begin
        ent_vld_p1[free_idx]  <= 1'b1;
        ent_src1_p1[free_idx] <= bus.enq_src1_state || wb_hit(bus.enq_prs1, bus.wb_valid, bus.wb_prd);
        ent_src2_p1[free_idx] <= bus.enq_src2_state || wb_hit(bus.enq_prs2, bus.wb_valid, bus.wb_prd);
      end
      occ_p1 <= occ_sum[OCC_W-1:0];
    end
  end

  // Entry data fields carry no reset; they are qualified by ent_vld_p1
  always_ff @(posedge clock) begin
    if (enq_fire) begin
      ent_prs1_p1[free_idx] <= bus.enq_prs1;
      ent_prs2_p1[free_idx] <= bus.enq_prs2;
      ent_flag_p1[free_idx] <= bus.enq_robidx_flag;
      ent_idx_p1[free_idx]  <= bus.enq_robidx;
      ent_pl_p1[free_idx]   <= bus.enq_payload;
    end
  end

  occ_bounds_a: assert property (@(posedge clock) disable iff (reset)
                                 occ_sum >= 0 && occ_sum <= DEPTH);
endmodule

// File: tb/tb_issue_queue_multi.sv
// Directed bench for issue_queue_multi with an in-order scoreboard of expected issues.
module tb_issue_queue_multi;
  localparam int DEPTH = 8, NUM_WB = 2, PREG_W = 6, ROB_W = 6, PAYLOAD_W = 128;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  typedef struct packed { logic flag; logic [ROB_W-1:0] idx; } sb_t;
  sb_t sb [$];

  issue_queue_multi_if #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .PREG_W(PREG_W),
                         .ROB_W(ROB_W), .PAYLOAD_W(PAYLOAD_W)) ifc ();

  issue_queue_multi #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .PREG_W(PREG_W),
                      .ROB_W(ROB_W), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (ifc)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [PAYLOAD_W-1:0] pl(input logic [ROB_W-1:0] idx);
    return {8{{10'h3A5, idx}}};
  endfunction

  task automatic check(input string tag, input logic [PAYLOAD_W-1:0] obs,
                       input logic [PAYLOAD_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ifc.enq_valid         = 1'b0;
    ifc.enq_prs1          = '0;
    ifc.enq_prs2          = '0;
    ifc.enq_src1_state    = 1'b0;
    ifc.enq_src2_state    = 1'b0;
    ifc.enq_robidx_flag   = 1'b0;
    ifc.enq_robidx        = '0;
    ifc.enq_payload       = '0;
    ifc.wb_valid          = '0;
    ifc.wb_prd            = '0;
    ifc.issue_ready       = 1'b0;
    ifc.flush_valid       = 1'b0;
    ifc.flush_robidx_flag = 1'b0;
    ifc.flush_robidx      = '0;
  endtask

  task automatic enq(input logic [PREG_W-1:0] p1, input logic [PREG_W-1:0] p2,
                     input logic s1, input logic s2, input logic flag,
                     input logic [ROB_W-1:0] idx);
    ifc.enq_valid       = 1'b1;
    ifc.enq_prs1        = p1;
    ifc.enq_prs2        = p2;
    ifc.enq_src1_state  = s1;
    ifc.enq_src2_state  = s2;
    ifc.enq_robidx_flag = flag;
    ifc.enq_robidx      = idx;
    ifc.enq_payload     = pl(idx);
  endtask

  task automatic expect_issue(input logic flag, input logic [ROB_W-1:0] idx);
    sb_t e;
    e.flag = flag;
    e.idx  = idx;
    sb.push_back(e);
  endtask

  // Accept n issues, comparing each against the head of the scoreboard.
  task automatic drain(input int n);
    sb_t e;
    for (int k = 0; k < n; k++) begin
      int waited;
      waited = 0;
      ifc.issue_ready = 1'b1;
      #1;
      while (!ifc.issue_valid && waited < 20) begin
        cyc();
        #1;
        waited++;
      end
      if (!ifc.issue_valid) check("drain_timeout", PAYLOAD_W'(ifc.issue_valid), 1);
      else if (sb.size() == 0) check("unexpected_issue", PAYLOAD_W'(ifc.issue_valid), 0);
      else begin
        e = sb.pop_front();
        check("issue_robidx", PAYLOAD_W'(ifc.issue_robidx), PAYLOAD_W'(e.idx));
        check("issue_flag", PAYLOAD_W'(ifc.issue_robidx_flag), PAYLOAD_W'(e.flag));
        check("issue_payload", ifc.issue_payload, pl(e.idx));
      end
      cyc();
    end
    ifc.issue_ready = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    check("rst_occ", PAYLOAD_W'(ifc.occupancy), 0);
    check("rst_issue_valid", PAYLOAD_W'(ifc.issue_valid), 0);
    check("rst_enq_ready", PAYLOAD_W'(ifc.enq_ready), 1);

    // Single ready entry issues the cycle after enqueue
    enq(6'd1, 6'd2, 1'b1, 1'b1, 1'b0, 6'd3);
    expect_issue(1'b0, 6'd3);
    cyc();
    idle();
    #1;
    check("t1_issue_valid", PAYLOAD_W'(ifc.issue_valid), 1);
    check("t1_occ", PAYLOAD_W'(ifc.occupancy), 1);
    drain(1);
    #1;
    check("t1_occ_after", PAYLOAD_W'(ifc.occupancy), 0);

    // Enqueue bypass from writeback port 1
    enq(6'd12, 6'd0, 1'b0, 1'b1, 1'b0, 6'd10);
    ifc.wb_valid = 2'b10;
    ifc.wb_prd   = {6'd12, 6'd0};
    expect_issue(1'b0, 6'd10);
    cyc();
    idle();
    #1;
    check("bypass_ready", PAYLOAD_W'(ifc.issue_valid), 1);
    drain(1);

    // Mismatched writeback leaves the entry waiting until its own preg arrives
    enq(6'd13, 6'd0, 1'b0, 1'b1, 1'b0, 6'd11);
    ifc.wb_valid = 2'b10;
    ifc.wb_prd   = {6'd12, 6'd0};
    cyc();
    idle();
    #1;
    check("no_bypass_wait", PAYLOAD_W'(ifc.issue_valid), 0);
    ifc.wb_valid = 2'b01;
    ifc.wb_prd   = {6'd0, 6'd13};
    expect_issue(1'b0, 6'd11);
    cyc();
    idle();
    drain(1);

    // Fill all entries, then selective wakeup on preg 5
    for (int i = 0; i < DEPTH; i++) begin
      enq((i < 3) ? 6'd5 : 6'd9, 6'd5, 1'b0, 1'b0, 1'b0, ROB_W'(20 + i));
      cyc();
    end
    idle();
    #1;
    check("full_occ", PAYLOAD_W'(ifc.occupancy), DEPTH);
    check("full_enq_ready", PAYLOAD_W'(ifc.enq_ready), 0);
    check("full_no_issue", PAYLOAD_W'(ifc.issue_valid), 0);
    ifc.wb_valid = 2'b11;
    ifc.wb_prd   = {6'd33, 6'd5};
    #1;
    check("wake_same_cycle", PAYLOAD_W'(ifc.issue_valid), 0);
    cyc();
    idle();
    for (int i = 0; i < 3; i++) expect_issue(1'b0, ROB_W'(20 + i));
    ifc.issue_ready = 1'b1;
    ifc.enq_valid   = 1'b1;
    #1;
    check("wake_ready", PAYLOAD_W'(ifc.issue_valid), 1);
    check("full_issue_no_enq", PAYLOAD_W'(ifc.enq_ready), 0);
    ifc.enq_valid = 1'b0;
    drain(3);
    #1;
    check("wait_on_9", PAYLOAD_W'(ifc.issue_valid), 0);
    check("occ_after_3", PAYLOAD_W'(ifc.occupancy), 5);
    ifc.wb_valid = 2'b11;
    ifc.wb_prd   = {6'd9, 6'd9};
    cyc();
    idle();
    for (int i = 3; i < DEPTH; i++) expect_issue(1'b0, ROB_W'(20 + i));
    drain(5);
    #1;
    check("fill_drained_occ", PAYLOAD_W'(ifc.occupancy), 0);

    // Wrapped ROB age: idx 60 flag 0 is older than idx 2 flag 1
    enq(6'd1, 6'd1, 1'b1, 1'b1, 1'b1, 6'd2);
    cyc();
    enq(6'd1, 6'd1, 1'b1, 1'b1, 1'b0, 6'd60);
    cyc();
    idle();
    expect_issue(1'b0, 6'd60);
    expect_issue(1'b1, 6'd2);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_sel", PAYLOAD_W'(ifc.issue_robidx), 60);
      cyc();
    end
    drain(2);

    // Flush at 7 removes 9, keeps 4 and 7; enqueue and issue suppressed that cycle
    enq(6'd1, 6'd1, 1'b1, 1'b1, 1'b0, 6'd4);
    cyc();
    enq(6'd1, 6'd1, 1'b1, 1'b1, 1'b0, 6'd7);
    cyc();
    enq(6'd1, 6'd1, 1'b1, 1'b1, 1'b0, 6'd9);
    cyc();
    enq(6'd1, 6'd1, 1'b1, 1'b1, 1'b0, 6'd5);
    ifc.flush_valid       = 1'b1;
    ifc.flush_robidx_flag = 1'b0;
    ifc.flush_robidx      = 6'd7;
    ifc.issue_ready       = 1'b1;
    #1;
    check("flush_enq_ready", PAYLOAD_W'(ifc.enq_ready), 0);
    check("flush_issue_valid", PAYLOAD_W'(ifc.issue_valid), 0);
    cyc();
    idle();
    #1;
    check("flush_occ", PAYLOAD_W'(ifc.occupancy), 2);
    expect_issue(1'b0, 6'd4);
    expect_issue(1'b0, 6'd7);
    drain(2);
    #1;
    check("flush_drained", PAYLOAD_W'(ifc.issue_valid), 0);
    check("flush_occ_end", PAYLOAD_W'(ifc.occupancy), 0);

    // Reset mid-stream discards everything, later wakeups find nothing
    for (int i = 0; i < 5; i++) begin
      enq(6'd40, 6'd1, 1'b0, 1'b1, 1'b0, ROB_W'(30 + i));
      cyc();
    end
    idle();
    #1;
    check("pre_reset_occ", PAYLOAD_W'(ifc.occupancy), 5);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    check("mid_rst_occ", PAYLOAD_W'(ifc.occupancy), 0);
    check("mid_rst_issue", PAYLOAD_W'(ifc.issue_valid), 0);
    check("mid_rst_enq_ready", PAYLOAD_W'(ifc.enq_ready), 1);
    ifc.wb_valid = 2'b01;
    ifc.wb_prd   = {6'd0, 6'd40};
    cyc();
    idle();
    #1;
    check("post_rst_wake", PAYLOAD_W'(ifc.issue_valid), 0);
    check("sb_empty", PAYLOAD_W'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
